// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready word input and a registered bit stream output.
// Frames are WIDTH bits long, shifted MSB or LSB first. Back-to-back frames run without a gap
// when the next word is accepted in the final bit cycle.
// Optional feature: define SERIALIZER_PARITY_EN to append one even-parity bit to every frame.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout_bit,
    output logic             bit_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              data_ready_q, data_ready_d;
    logic              dout_q, dout_d;
    logic              bit_valid_q, bit_valid_d;
    logic              word_done_q, word_done_d;
`ifdef SERIALIZER_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              handshake;
    logic              frame_end;
    logic              first_bit;
    logic              next_bit;
    logic [WIDTH-1:0]  load_shifted;
    logic [WIDTH-1:0]  sh_shifted;

    // Bit selection and shifting for the configured order; cnt_q counts bits already presented.
    always_comb begin
        if (MSB_FIRST != 0) begin
            first_bit    = data_in[WIDTH-1];
            next_bit     = sh_q[WIDTH-1];
            load_shifted = {data_in[WIDTH-2:0], 1'b0};
            sh_shifted   = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            first_bit    = data_in[0];
            next_bit     = sh_q[0];
            load_shifted = {1'b0, data_in[WIDTH-1:1]};
            sh_shifted   = {1'b0, sh_q[WIDTH-1:1]};
        end
        handshake = data_valid && data_ready_q;
`ifdef SERIALIZER_PARITY_EN
        frame_end = (state_q == StParity);
`else
        frame_end = (state_q == StShift) && (cnt_q == CntW'(WIDTH));
`endif
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        data_ready_d = 1'b0;
        dout_d       = 1'b0;
        bit_valid_d  = 1'b0;
        word_done_d  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d        = par_q;
`endif
        if (handshake) begin
            // data_ready_q is only high in IDLE or the final frame bit, so this also covers
            // the back-to-back case.
            state_d     = StShift;
            sh_d        = load_shifted;
            cnt_d       = CntW'(1);
            dout_d      = first_bit;
            bit_valid_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            par_d       = ^data_in;
`endif
        end else if ((state_q == StIdle) || frame_end) begin
            state_d      = StIdle;
            cnt_d        = '0;
            data_ready_d = 1'b1;
        end else begin
`ifdef SERIALIZER_PARITY_EN
            if (cnt_q == CntW'(WIDTH)) begin
                state_d      = StParity;
                dout_d       = par_q;
                bit_valid_d  = 1'b1;
                word_done_d  = 1'b1;
                data_ready_d = 1'b1;
            end else begin
                sh_d        = sh_shifted;
                cnt_d       = cnt_q + 1'b1;
                dout_d      = next_bit;
                bit_valid_d = 1'b1;
            end
`else
            sh_d        = sh_shifted;
            cnt_d       = cnt_q + 1'b1;
            dout_d      = next_bit;
            bit_valid_d = 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
                word_done_d  = 1'b1;
                data_ready_d = 1'b1;
            end
`endif
        end
    end

    // State and output registers with synchronous reset; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sh_q         <= '0;
            cnt_q        <= '0;
            data_ready_q <= 1'b0;
            dout_q       <= 1'b0;
            bit_valid_q  <= 1'b0;
            word_done_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            data_ready_q <= data_ready_d;
            dout_q       <= dout_d;
            bit_valid_q  <= bit_valid_d;
            word_done_q  <= word_done_d;
`ifdef SERIALIZER_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign data_ready = data_ready_q;
    assign dout_bit   = dout_q;
    assign bit_valid  = bit_valid_q;
    assign busy       = bit_valid_q;
    assign word_done  = word_done_q;

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning shift order (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port data_valid  input  1  upstream word available.
REQ-007 SHALL have port data_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port dout_bit  output  1  serial bit; drives the downstream sequence detector's din.
REQ-009 SHALL have port bit_valid  output  1  dout_bit carries a frame bit this cycle.
REQ-010 SHALL have port busy  output  1  a word is being shifted out.
REQ-011 SHALL have port word_done  output  1  one-cycle pulse on the final bit of a frame.

Function
REQ-012 SHALL implement a state machine with states IDLE, SHIFT and, when parity is compiled in, PARITY.
REQ-013 SHALL complete a handshake in any cycle where data_valid and data_ready are both 1, capturing data_in into an internal shift register.
REQ-014 SHALL present the first frame bit on dout_bit, with bit_valid=1, in the cycle immediately after the handshake (latency 1).
REQ-015 SHALL present exactly one new bit per cycle for WIDTH consecutive cycles in SHIFT, in the order set by MSB_FIRST.
REQ-016 SHALL keep all outputs registered, with no combinational path from data_in or data_valid to any output.
REQ-017 SHALL drive data_ready=1 in IDLE and in the final frame-bit cycle, and 0 in every other cycle.
REQ-018 SHALL, on a handshake in the final frame-bit cycle, start the next frame's first bit in the following cycle with no gap (back-to-back).
REQ-019 SHALL, when no handshake occurs in the final frame-bit cycle, return to IDLE, with bit_valid=0 and busy=0 in the next cycle.
REQ-020 SHALL hold dout_bit=0 whenever bit_valid=0.
REQ-021 SHALL ignore data_valid and data_in while data_ready=0; upstream holds the word until accepted.
REQ-022 SHALL assert busy=1 in every cycle where bit_valid=1, and 0 otherwise.
REQ-023 SHALL pulse word_done=1 only in the final frame-bit cycle: the last data bit without parity, or the parity bit with parity.
REQ-024 SHALL size the bit counter as $clog2(WIDTH+1) bits and SHALL NOT let it wrap inside a frame.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, force state to IDLE and drive data_ready=0, dout_bit=0, bit_valid=0, busy=0 and word_done=0.
REQ-026 SHALL drive data_ready=1 in the first cycle after rst deasserts.
REQ-027 SHALL, on reset asserted mid-frame, discard the partial word, never resume it, and emit no word_done for it.
REQ-028 SHALL give rst priority over a simultaneous handshake, with no word captured.

Configuration
REQ-029 SHALL, when macro SERIALIZER_PARITY_EN is defined, append one even-parity bit (XOR of all WIDTH data bits) after the last data bit, using state PARITY, with bit_valid=1; the frame is then WIDTH+1 cycles.
REQ-030 SHALL, when SERIALIZER_PARITY_EN is undefined, omit the PARITY state entirely; the frame is then WIDTH cycles.

Verification
REQ-031 SHALL cover: WIDTH=8, MSB_FIRST=1, no parity, handshake 8'hA5 -> dout_bit 1,0,1,0,0,1,0,1 on cycles +1..+8, word_done on cycle +8, bit_valid=0 on cycle +9.
REQ-032 SHALL cover: MSB_FIRST=0, word 8'h01 -> dout_bit 1 then seven 0s, with busy=1 throughout.
REQ-033 SHALL cover: SERIALIZER_PARITY_EN defined, word 8'h07 -> bits 0,0,0,0,0,1,1,1 then parity 1 on cycle +9, word_done on cycle +9.
REQ-034 SHALL cover: 8'hFF then 8'h00, with data_valid held high -> sixteen contiguous bit_valid cycles (eight 1s then eight 0s), and data_ready high only on cycles +8 and +16.
REQ-035 SHALL cover: rst=1 at cycle +4 of word 8'hF0 -> bit_valid=0, busy=0 and data_ready=0 during reset, no word_done, and data_ready=1 in the cycle after release.
REQ-036 SHALL cover: data_valid=1 with data_in changing while busy and not in the final cycle -> the in-flight bit stream is unchanged.
